top_module_core: RTL and testbench

Synchronous first-word-fall-through (FWFT) FIFO with valid/ready handshakes on both sides, occupancy count, flush and almost-full flag. It is the top-level datapath block instantiated by the simulation environment's default bench. It buffers a stream between a producer and a consumer that share one clock.

---
 rtl/top_module_core.sv | 89 ++++++++
 tb/tb_top_module_core.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/top_module_core.sv
// top_module_core: single-clock first-word-fall-through FIFO with valid/ready
// handshakes on both sides, occupancy count, synchronous flush and an
// almost-full flag.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   flush            synchronous clear of pointers and count (beats push/pop)
//   in_valid/ready   producer handshake; in_ready = !full
//   in_data          write payload
//   out_valid/ready  consumer handshake; out_valid = !empty
//   out_data         head entry, 0 when empty
//   count            entries stored, 0..DEPTH
//   full/empty       count == DEPTH / count == 0
//   almost_full      count >= AF_LEVEL
module top_module_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    // Status is decoded from the registered count only.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == CW'(0));
    assign almost_full = (count >= CW'(AF_LEVEL));
    assign in_ready    = !full;
    assign out_valid   = !empty;

    assign push = in_valid && !full;
    assign pop  = out_ready && !empty;

    // Head entry falls through; forced to zero while empty.
    assign out_data = empty ? DATA_W'(0) : mem[rd_ptr];

    // Pointer and count state; flush wins over any handshake in its cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= PW'(0);
            rd_ptr <= PW'(0);
            count  <= CW'(0);
        end else if (flush) begin
            wr_ptr <= PW'(0);
            rd_ptr <= PW'(0);
            count  <= CW'(0);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_top_module_core.sv
// Scoreboard bench for top_module_core: the driver issues stimulus, a queue
// holds the expected FIFO contents, and a monitor checks outputs on every
// falling edge.
module tb_top_module_core;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 12;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic [4:0]          count;
    logic                full;
    logic                empty;
    logic                almost_full;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] sb_q [$];

    top_module_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Compare all outputs against the expected contents held in sb_q.
    task automatic check_status(string tag);
        int n;
        n = sb_q.size();
        check({tag, " count"}, int'(count), n);
        check({tag, " full"}, int'(full), int'(n == DEPTH));
        check({tag, " empty"}, int'(empty), int'(n == 0));
        check({tag, " almost_full"}, int'(almost_full), int'(n >= AF_LEVEL));
        check({tag, " in_ready"}, int'(in_ready), int'(n < DEPTH));
        check({tag, " out_valid"}, int'(out_valid), int'(n > 0));
        check({tag, " out_data"}, int'(out_data), (n > 0) ? int'(sb_q[0]) : 0);
    endtask

    // Monitor: status every cycle, scoreboard compare whenever a pop is offered.
    initial begin
        forever begin
            @(negedge clk);
            check_status("status");
            if (!rst && !flush && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop on empty scoreboard", 1, 0);
                end else begin
                    check("pop data", int'(out_data), int'(sb_q[0]));
                end
            end
        end
    end

    // Reference model: predicts what the coming rising edge does to the contents.
    initial begin
        forever begin
            bit do_push;
            bit do_pop;
            @(negedge clk);
            #1;
            if (rst || flush) begin
                sb_q.delete();
            end else begin
                do_push = in_valid && (sb_q.size() < DEPTH);
                do_pop  = out_ready && (sb_q.size() > 0);
                if (do_pop) void'(sb_q.pop_front());
                if (do_push) sb_q.push_back(in_data);
            end
        end
    end

    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
        idle();
    endtask

    // Assert reset between edges and check outputs before any clock edge.
    task automatic async_reset(string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        sb_q.delete();
        #1;
        check_status(tag);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] pat;
        // Reset held for two cycles
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        idle();

        // Fill 0x01..0x10 then an ignored 0xFF
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        idle();
        #4;
        check("fill full", int'(full), 1);
        check("fill count", int'(count), DEPTH);

        // Drain in order
        drain();
        check("drain empty", int'(empty), 1);

        // Concurrent push/pop at count 5 across pointer wraps
        pat = 8'd1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pat, 1'b0, 1'b0);
            pat++;
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, pat, 1'b1, 1'b0);
            pat++;
        end
        idle();
        #4;
        check("concurrent count", int'(count), 5);
        drain();

        // Empty boundary: push and pop together
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        idle();
        #4;
        check("empty boundary count", int'(count), 1);
        drain();

        // Full boundary: push and pop together
        for (int i = 0; i < DEPTH; i++) step(1'b1, DATA_W'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        idle();
        #4;
        check("full boundary count", int'(count), DEPTH - 1);
        drain();

        // Flush with a simultaneous push of 0xAA, then push 0x55
        for (int i = 0; i < 7; i++) step(1'b1, DATA_W'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle();
        #4;
        check("post flush count", int'(count), 1);
        check("post flush head", int'(out_data), 8'h55);
        drain();

        // Reset asserted mid-stream
        for (int i = 0; i < 9; i++) step(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0);
        async_reset("mid reset");
        idle();

        // Randomized traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 60), DATA_W'($urandom),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
        end
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 40), DATA_W'($urandom),
                 1'($urandom_range(0, 99) < 70), 1'b0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
